// File: rtl/instr_fetch_stage_pkg.sv
// Shared fetch-stage definitions: RV32 base opcodes, the bubble instruction and the fetch FSM encoding.
package riscv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } fetch_state_t;

    // An empty IF/ID slot must look like opcode 0 so the control unit emits a bubble.
    function automatic logic [6:0] slot_opcode(input logic valid, input logic [31:0] instr);
        return valid ? instr[6:0] : 7'b0;
    endfunction

endpackage

// File: rtl/instr_fetch_stage_if.sv
// Instruction-memory request/acknowledge port between the fetch stage and the memory.
interface instr_fetch_stage_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [31:0]     imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/instr_fetch_stage_skid_buf.sv
// One-entry {pc, instr} holding buffer for a fetch that returns while decode is stalled.
module fetch_skid_buf #(
    parameter int          XLEN      = 32,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            unload,
    input  logic            clear,
    input  logic [XLEN-1:0] load_pc,
    input  logic [31:0]     load_instr,
    output logic            full,
    output logic [XLEN-1:0] pc,
    output logic [31:0]     instr
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
        end else if (clear || unload) begin
            full <= 1'b0;
        end else if (load) begin
            full <= 1'b1;
        end
    end

    // Payload is only meaningful while full, so it is captured without regard to clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc    <= '0;
            instr <= NOP_INSTR;
        end else if (load) begin
            pc    <= load_pc;
            instr <= load_instr;
        end
    end

endmodule

// File: rtl/instr_fetch_stage.sv
// Fetch stage: PC register, req/ack fetch FSM with stall skid and branch drain, and the IF/ID register.
module instr_fetch_stage #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic                clk,
    input  logic                rst_n,
    instr_fetch_stage_if.master imem,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [XLEN-1:0]     branch_target,
    output logic                if_id_valid,
    output logic [XLEN-1:0]     if_id_pc,
    output logic [31:0]         if_id_instr,
    output logic [6:0]          opcode
);
    import riscv_pkg::*;

    // state   | meaning
    // S_BOOT  | one idle cycle after reset, no request
    // S_FETCH | request outstanding at pc
    // S_HOLD  | fetched word parked in skid while decode stalls
    // S_DRAIN | flushed request still outstanding at its old address

    fetch_state_t    state, state_nxt;
    logic [XLEN-1:0] pc, pc_nxt, drain_addr;
    logic [XLEN-1:0] target_aligned;
    logic            fetch_ack;
    logic            skid_load, skid_unload, skid_full;
    logic [XLEN-1:0] skid_pc;
    logic [31:0]     skid_instr;
    logic            ifid_from_mem, ifid_from_skid;

    assign target_aligned = {branch_target[XLEN-1:2], 2'b00};
    assign fetch_ack      = (state == S_FETCH) && imem.imem_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_BOOT:  state_nxt = S_FETCH;
            S_FETCH: begin
                if (branch_taken) begin
                    state_nxt = imem.imem_ack ? S_FETCH : S_DRAIN;
                end else if (imem.imem_ack && stall) begin
                    state_nxt = S_HOLD;
                end
            end
            S_HOLD:  begin
                if (branch_taken || !stall) begin
                    state_nxt = S_FETCH;
                end
            end
            S_DRAIN: begin
                if (imem.imem_ack) begin
                    state_nxt = S_FETCH;
                end
            end
            default: state_nxt = S_BOOT;
        endcase
    end

    always_comb begin
        imem.imem_req  = (state == S_FETCH) || (state == S_DRAIN);
        imem.imem_addr = (state == S_DRAIN) ? drain_addr : pc;
        skid_load      = fetch_ack && stall && !branch_taken;
        skid_unload    = (state == S_HOLD) && !stall && !branch_taken;
        ifid_from_mem  = fetch_ack && !stall && !branch_taken;
        ifid_from_skid = skid_unload && skid_full;
    end

    // A redirect always wins; otherwise pc only advances on an accepted fetch.
    always_comb begin
        pc_nxt = pc;
        if (branch_taken) begin
            pc_nxt = target_aligned;
        end else if (fetch_ack) begin
            pc_nxt = pc + XLEN'(4);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_nxt;
        end
    end

    // pc already holds the target once draining, so the abandoned address is kept separately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drain_addr <= '0;
        end else if ((state == S_FETCH) && branch_taken && !imem.imem_ack) begin
            drain_addr <= pc;
        end
    end

    fetch_skid_buf #(
        .XLEN      (XLEN),
        .NOP_INSTR (NOP_INSTR)
    ) u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (skid_load),
        .unload     (skid_unload),
        .clear      (branch_taken),
        .load_pc    (pc),
        .load_instr (imem.imem_rdata),
        .full       (skid_full),
        .pc         (skid_pc),
        .instr      (skid_instr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_id_valid <= 1'b0;
            if_id_pc    <= '0;
            if_id_instr <= NOP_INSTR;
        end else if (branch_taken) begin
            if_id_valid <= 1'b0;
        end else if (!stall) begin
            if (ifid_from_mem) begin
                if_id_valid <= 1'b1;
                if_id_pc    <= pc;
                if_id_instr <= imem.imem_rdata;
            end else if (ifid_from_skid) begin
                if_id_valid <= 1'b1;
                if_id_pc    <= skid_pc;
                if_id_instr <= skid_instr;
            end else begin
                if_id_valid <= 1'b0;
            end
        end
    end

    assign opcode = slot_opcode(if_id_valid, if_id_instr);

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed bench for instr_fetch_stage: latency-programmable memory model plus a scoreboard monitor on IF/ID.
module tb_instr_fetch_stage;
    import riscv_pkg::*;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic [6:0]  opcode;

    int   lat = 1;
    logic mem_en = 1'b1;
    int   wait_cnt;
    logic was_stall = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t exp_q[$];

    instr_fetch_stage_if #(.XLEN(32)) mif ();

    instr_fetch_stage #(
        .XLEN      (32),
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0013)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem          (mif.master),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .if_id_valid   (if_id_valid),
        .if_id_pc      (if_id_pc),
        .if_id_instr   (if_id_instr),
        .opcode        (opcode)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        logic [6:0] op;
        case (a[4:2])
            3'd0:    op = OP_IMM;
            3'd1:    op = OP_R;
            3'd2:    op = OP_LOAD;
            3'd3:    op = OP_STORE;
            3'd4:    op = OP_BRANCH;
            default: op = OP_IMM;
        endcase
        return {a[26:2], op};
    endfunction

    // Memory answers after lat cycles of a held request; lat=1 acks in the request cycle.
    always_comb begin
        mif.imem_ack   = mem_en && mif.imem_req && (wait_cnt >= lat - 1);
        mif.imem_rdata = mif.imem_ack ? instr_of(mif.imem_addr) : 32'hDEAD_BEEF;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) wait_cnt <= 0;
        else if (!mif.imem_req || mif.imem_ack || !mem_en) wait_cnt <= 0;
        else wait_cnt <= wait_cnt + 1;
    end

    always @(posedge clk) was_stall <= stall;

    // A new IF/ID entry is visible whenever it is valid and the preceding edge was not a stall hold.
    always @(negedge clk) begin
        if (rst_n && if_id_valid && !was_stall) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL sb_unexpected: got pc=%h instr=%h, expected none", if_id_pc, if_id_instr);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (if_id_pc !== e.pc || if_id_instr !== e.instr || opcode !== e.instr[6:0]) begin
                    n_bad++;
                    $display("FAIL sb_entry: got pc=%h instr=%h op=%b, expected pc=%h instr=%h op=%b",
                             if_id_pc, if_id_instr, opcode, e.pc, e.instr, e.instr[6:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc);
        exp_t e;
        e.pc    = pc;
        e.instr = instr_of(pc);
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        mem_en = 1'b1;
        lat = 1;
        stall = 1'b0;
        branch_taken = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // Test 1: reset values, then zero-wait memory
        @(negedge clk);
        check("rst_req", 64'(mif.imem_req), 64'd0);
        check("rst_valid", 64'(if_id_valid), 64'd0);
        check("rst_pc", 64'(if_id_pc), 64'h0);
        check("rst_instr", 64'(if_id_instr), 64'h0000_0013);
        check("rst_opcode", 64'(opcode), 64'd0);
        for (int k = 0; k < 4; k++) push(32'(4 * k));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t1_req", 64'(mif.imem_req), 64'd1);
        check("t1_addr0", 64'(mif.imem_addr), 64'h0);
        check("t1_valid0", 64'(if_id_valid), 64'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t1_valid", 64'(if_id_valid), 64'd1);
            check("t1_seq_pc", 64'(if_id_pc), 64'(4 * k));
        end
        mem_en = 1'b0;

        // Test 2: three-cycle memory latency
        push(32'h10);
        push(32'h14);
        @(negedge clk);
        lat = 3;
        mem_en = 1'b1;
        check("t2_addr_a", 64'(mif.imem_addr), 64'h10);
        check("t2_gap_op_a", 64'(opcode), 64'd0);
        @(negedge clk);
        check("t2_addr_b", 64'(mif.imem_addr), 64'h10);
        check("t2_gap_op_b", 64'(opcode), 64'd0);
        @(negedge clk);
        check("t2_addr_c", 64'(mif.imem_addr), 64'h10);
        check("t2_req_c", 64'(mif.imem_req), 64'd1);
        @(negedge clk);
        check("t2_pc10", 64'(if_id_pc), 64'h10);
        check("t2_op10", 64'(opcode), 64'(OP_BRANCH));
        check("t2_addr14", 64'(mif.imem_addr), 64'h14);
        @(negedge clk);
        check("t2_gap_op_d", 64'(opcode), 64'd0);
        @(negedge clk);
        @(negedge clk);
        check("t2_pc14", 64'(if_id_pc), 64'h14);
        mem_en = 1'b0;

        // Test 3: stall for two cycles across the ack of pc 8
        do_reset();
        for (int k = 0; k < 4; k++) push(32'(4 * k));
        repeat (3) @(negedge clk);
        check("t3_pc4", 64'(if_id_pc), 64'h4);
        stall = 1'b1;
        @(negedge clk);
        check("t3_hold_pc", 64'(if_id_pc), 64'h4);
        check("t3_hold_req", 64'(mif.imem_req), 64'd0);
        @(negedge clk);
        check("t3_hold_pc2", 64'(if_id_pc), 64'h4);
        check("t3_hold_valid", 64'(if_id_valid), 64'd1);
        stall = 1'b0;
        @(negedge clk);
        check("t3_skid_pc8", 64'(if_id_pc), 64'h8);
        @(negedge clk);
        check("t3_pc12", 64'(if_id_pc), 64'hC);
        mem_en = 1'b0;

        // Test 4: branch to 0x100 while a slow fetch of 0x10 is outstanding
        push(32'h100);
        @(negedge clk);
        lat = 3;
        mem_en = 1'b1;
        check("t4_addr10", 64'(mif.imem_addr), 64'h10);
        @(negedge clk);
        branch_taken = 1'b1;
        branch_target = 32'h100;
        @(negedge clk);
        branch_taken = 1'b0;
        check("t4_drain_addr", 64'(mif.imem_addr), 64'h10);
        check("t4_drain_req", 64'(mif.imem_req), 64'd1);
        check("t4_flush_valid", 64'(if_id_valid), 64'd0);
        @(negedge clk);
        check("t4_new_addr", 64'(mif.imem_addr), 64'h100);
        check("t4_no_10", 64'(if_id_valid), 64'd0);
        repeat (3) @(negedge clk);
        check("t4_pc100", 64'(if_id_pc), 64'h100);

        // Test 5: branch and stall together, misaligned target
        lat = 1;
        stall = 1'b1;
        branch_taken = 1'b1;
        branch_target = 32'h103;
        push(32'h100);
        push(32'h104);
        @(negedge clk);
        check("t5_valid0", 64'(if_id_valid), 64'd0);
        check("t5_op0", 64'(opcode), 64'd0);
        check("t5_addr", 64'(mif.imem_addr), 64'h100);
        stall = 1'b0;
        branch_taken = 1'b0;
        @(negedge clk);
        check("t5_pc100", 64'(if_id_pc), 64'h100);
        @(negedge clk);
        check("t5_pc104", 64'(if_id_pc), 64'h104);
        mem_en = 1'b0;

        // Test 6: asynchronous reset while fetching 0x20
        do_reset();
        for (int k = 0; k < 8; k++) push(32'(4 * k));
        repeat (9) @(negedge clk);
        check("t6_addr20", 64'(mif.imem_addr), 64'h20);
        check("t6_pc1c", 64'(if_id_pc), 64'h1C);
        mem_en = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_req", 64'(mif.imem_req), 64'd0);
        check("t6_rst_addr", 64'(mif.imem_addr), 64'h0);
        check("t6_rst_pc", 64'(if_id_pc), 64'h0);
        check("t6_rst_instr", 64'(if_id_instr), 64'h0000_0013);
        check("t6_rst_valid", 64'(if_id_valid), 64'd0);
        push(32'h0);
        push(32'h4);
        @(negedge clk);
        mem_en = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_first_addr", 64'(mif.imem_addr), 64'h0);
        check("t6_first_req", 64'(mif.imem_req), 64'd1);
        @(negedge clk);
        check("t6_pc0", 64'(if_id_pc), 64'h0);
        @(negedge clk);
        check("t6_pc4", 64'(if_id_pc), 64'h4);
        mem_en = 1'b0;
        repeat (2) @(negedge clk);

        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
